// File: rtl/nios2_key_pio_if.sv
// nios2_key_pio_if: Avalon-MM slave bus bundle for the key input PIO
interface nios2_key_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/nios2_key_pio.sv
// nios2_key_pio: Avalon-MM input PIO with synchronizer, debouncer, edge capture and level irq
module nios2_key_pio #(
  parameter int WIDTH = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE = 1,
  parameter int RESET_LEVEL = 1,
  parameter int BIT_CLEAR = 1
) (
  input  logic              clk,
  input  logic              reset,
  nios2_key_pio_if.slave    bus,
  input  logic [WIDTH-1:0]  in_port,
  output logic              irq
);
  localparam int CW = DEBOUNCE_CYCLES > 0 ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [WIDTH-1:0] RST_V = {WIDTH{RESET_LEVEL[0]}};
  logic [WIDTH-1:0] s1_q, s2_q, deb, deb_d_q, ev, clr;
  logic [WIDTH-1:0] mask_q, mask_d, cap_q, cap_d;
  logic [31:0] rd_q, rd_d;
  logic irq_q, irq_d, wr;
  logic unused_wd;
  assign unused_wd = ^bus.writedata;
  assign bus.readdata = rd_q;
  assign irq = irq_q;
  // two-flop synchronizer; in_port is never used combinationally
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      s1_q <= RST_V;
      s2_q <= RST_V;
    end else begin
      s1_q <= in_port;
      s2_q <= s1_q;
    end
  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    assign deb = s2_q;
  end else begin : g_deb
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic [CW-1:0] cnt_q;
      logic deb_q;
      // accept a new level only after it has differed for DEBOUNCE_CYCLES consecutive cycles
      always_ff @(posedge clk or posedge reset)
        if (reset) begin
          cnt_q <= '0;
          deb_q <= RESET_LEVEL[0];
        end else if (s2_q[i] == deb_q) cnt_q <= '0;
        else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
          deb_q <= s2_q[i];
          cnt_q <= '0;
        end else cnt_q <= cnt_q + 1'b1;
      assign deb[i] = deb_q;
    end
  end
  // edge detect, register writes and read mux; a new edge beats a same-cycle clear
  always_comb begin
    wr = bus.chipselect & ~bus.write_n;
    ev = EDGE_TYPE == 0 ? deb & ~deb_d_q : EDGE_TYPE == 1 ? ~deb & deb_d_q : deb ^ deb_d_q;
    clr = (wr && bus.address == 2'd3) ? (BIT_CLEAR != 0 ? bus.writedata[WIDTH-1:0] : '1) : '0;
    cap_d = ev | (cap_q & ~clr);
    mask_d = (wr && bus.address == 2'd2) ? bus.writedata[WIDTH-1:0] : mask_q;
    irq_d = |(cap_d & mask_d);
    rd_d = '0;
    rd_d[WIDTH-1:0] = bus.address == 2'd0 ? deb : bus.address == 2'd2 ? mask_q :
                      bus.address == 2'd3 ? cap_q : '0;
  end
  // state registers for edge history, mask, capture, read data and irq
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      deb_d_q <= RST_V;
      mask_q  <= '0;
      cap_q   <= '0;
      rd_q    <= '0;
      irq_q   <= 1'b0;
    end else begin
      deb_d_q <= deb;
      mask_q  <= mask_d;
      cap_q   <= cap_d;
      rd_q    <= rd_d;
      irq_q   <= irq_d;
    end
endmodule
